// File: rtl/yv_cmult_pipe_pkg.sv
// rtl/yv_cmult_pipe_pkg.sv - shared complex-word constants and helpers for the YV multiply/accumulate path
package yv_cmult_pipe_pkg;

  localparam int YV_WIDTH = 48;
  localparam int YV_FRAC  = 22;
  localparam int YV_CW    = YV_WIDTH / 2;

  localparam logic signed [YV_CW-1:0] YV_SAT_MAX = 24'h7FFFFF;
  localparam logic signed [YV_CW-1:0] YV_SAT_MIN = 24'h800000;

  function automatic logic signed [YV_CW-1:0] cplx_re(input logic [YV_WIDTH-1:0] w);
    return w[YV_WIDTH-1:YV_CW];
  endfunction

  function automatic logic signed [YV_CW-1:0] cplx_im(input logic [YV_WIDTH-1:0] w);
    return w[YV_CW-1:0];
  endfunction

  function automatic logic [YV_WIDTH-1:0] cplx_pack(input logic signed [YV_CW-1:0] re,
                                                    input logic signed [YV_CW-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/yv_cmult_pipe_cmult_core.sv
// rtl/yv_cmult_pipe_cmult_core.sv - S2 partial products and S3 combine/scale/saturate
module cmult_core
  import yv_cmult_pipe_pkg::*;
#(
  parameter int WIDTH = YV_WIDTH,
  parameter int FRAC  = YV_FRAC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s2_en,
  input  logic             s3_en,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] yv
);

  localparam int CW = WIDTH / 2;
  localparam int PW = 2 * CW;
  localparam int SW = PW + 1;

  localparam logic signed [SW-1:0] MAXV = $signed({{(SW-CW+1){1'b0}}, {(CW-1){1'b1}}});
  localparam logic signed [SW-1:0] MINV = $signed({{(SW-CW+1){1'b1}}, {(CW-1){1'b0}}});

  logic signed [CW-1:0] yr, yi, vr, vi;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] re_sum, im_sum, re_sh, im_sh;

  assign yr = y[WIDTH-1:CW];
  assign yi = y[CW-1:0];
  assign vr = v[WIDTH-1:CW];
  assign vi = v[CW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (s2_en) begin
      p_rr <= PW'(yr) * PW'(vr);
      p_ii <= PW'(yi) * PW'(vi);
      p_ri <= PW'(yr) * PW'(vi);
      p_ir <= PW'(yi) * PW'(vr);
    end
  end

  assign re_sum = SW'(p_rr) - SW'(p_ii);
  assign im_sum = SW'(p_ri) + SW'(p_ir);
  // Arithmetic shift floors toward minus infinity before clamping.
  assign re_sh  = re_sum >>> FRAC;
  assign im_sh  = im_sum >>> FRAC;

  function automatic logic [CW-1:0] sat(input logic signed [SW-1:0] x);
    if (x > MAXV)      return MAXV[CW-1:0];
    else if (x < MINV) return MINV[CW-1:0];
    else               return x[CW-1:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      yv <= '0;
    end else if (s3_en) begin
      yv <= {sat(re_sh), sat(im_sh)};
    end
  end

endmodule

// File: rtl/yv_cmult_pipe.sv
// rtl/yv_cmult_pipe.sv - 3-stage complex multiplier with frame first/last tagging
module yv_cmult_pipe
  import yv_cmult_pipe_pkg::*;
#(
  parameter int WIDTH = YV_WIDTH,
  parameter int FRAC  = YV_FRAC,
  parameter int TERMS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] v_in,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] input_YV,
  output logic             out_valid,
  output logic             sel_sum_cycle,
  output logic             out_last
);

  localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);

  logic [CNT_W-1:0] cnt, cnt_cur;
  logic             tag_first, tag_last;

  logic [WIDTH-1:0] y_s1, v_s1;
  logic             vld_s1, vld_s2, vld_s3;
  logic             fst_s1, fst_s2, fst_s3;
  logic             lst_s1, lst_s2, lst_s3;

  // frame_clr repositions the current input itself, not just the next one.
  assign cnt_cur   = frame_clr ? '0 : cnt;
  assign tag_first = (cnt_cur == '0);
  assign tag_last  = (cnt_cur == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (in_valid) begin
      cnt <= tag_last ? '0 : cnt_cur + 1'b1;
    end else begin
      cnt <= cnt_cur;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_s1 <= '0;
      v_s1 <= '0;
    end else if (in_valid) begin
      y_s1 <= y_in;
      v_s1 <= v_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_s1 <= 1'b0;
      vld_s2 <= 1'b0;
      vld_s3 <= 1'b0;
      fst_s1 <= 1'b0;
      fst_s2 <= 1'b0;
      fst_s3 <= 1'b0;
      lst_s1 <= 1'b0;
      lst_s2 <= 1'b0;
      lst_s3 <= 1'b0;
    end else begin
      vld_s1 <= in_valid;
      vld_s2 <= vld_s1;
      vld_s3 <= vld_s2;
      fst_s1 <= in_valid & tag_first;
      fst_s2 <= vld_s1 & fst_s1;
      fst_s3 <= vld_s2 & fst_s2;
      lst_s1 <= in_valid & tag_last;
      lst_s2 <= vld_s1 & lst_s1;
      lst_s3 <= vld_s2 & lst_s2;
    end
  end

  cmult_core #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .s2_en (vld_s1),
    .s3_en (vld_s2),
    .y     (y_s1),
    .v     (v_s1),
    .yv    (input_YV)
  );

  assign out_valid     = vld_s3;
  assign sel_sum_cycle = vld_s3 & fst_s3;
  assign out_last      = vld_s3 & lst_s3;

endmodule

// File: tb/tb_yv_cmult_pipe.sv
// tb/tb_yv_cmult_pipe.sv - randomized self-checking bench for yv_cmult_pipe
module tb_yv_cmult_pipe;
  import yv_cmult_pipe_pkg::*;

  localparam int TERMS = 4;
  localparam int NSLOT = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [47:0] y_in = '0;
  logic [47:0] v_in = '0;
  logic        frame_clr = 1'b0;
  logic [47:0] input_YV;
  logic        out_valid, sel_sum_cycle, out_last;

  yv_cmult_pipe #(.WIDTH(48), .FRAC(22), .TERMS(TERMS)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .y_in          (y_in),
    .v_in          (v_in),
    .frame_clr     (frame_clr),
    .input_YV      (input_YV),
    .out_valid     (out_valid),
    .sel_sum_cycle (sel_sum_cycle),
    .out_last      (out_last)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit          e_v [NSLOT];
  bit          e_f [NSLOT];
  bit          e_l [NSLOT];
  logic [47:0] e_yv[NSLOT];
  logic [47:0] last_yv = '0;
  int          t = 0;
  int          pos = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h want=%h", tag, t, obs, exp);
    end
  endtask

  function automatic longint clamp24(input longint x);
    if (x > 64'sd8388607)  return 64'sd8388607;
    if (x < -64'sd8388608) return -64'sd8388608;
    return x;
  endfunction

  // Reference: whole-number complex product, floor-divided by 2^22, clamped per component.
  function automatic logic [47:0] ref_mul(input logic [47:0] y, input logic [47:0] v);
    longint yr, yi, vr, vi, re, im;
    yr = longint'(cplx_re(y));
    yi = longint'(cplx_im(y));
    vr = longint'(cplx_re(v));
    vi = longint'(cplx_im(v));
    re = clamp24((yr * vr - yi * vi) >>> 22);
    im = clamp24((yr * vi + yi * vr) >>> 22);
    return cplx_pack(24'(re), 24'(im));
  endfunction

  task automatic tick(input bit iv, input logic [47:0] y, input logic [47:0] v, input bit clr);
    in_valid  = iv;
    y_in      = y;
    v_in      = v;
    frame_clr = clr;
    if (clr) pos = 0;
    if (iv) begin
      e_v[t+2]  = 1'b1;
      e_yv[t+2] = ref_mul(y, v);
      e_f[t+2]  = (pos == 0);
      e_l[t+2]  = (pos == TERMS - 1);
      pos = (pos + 1) % TERMS;
    end
    @(posedge clock);
    @(negedge clock);
    if (e_v[t]) last_yv = e_yv[t];
    check("out_valid", 64'(out_valid), 64'(e_v[t]));
    check("sel_sum_cycle", 64'(sel_sum_cycle), 64'(e_f[t]));
    check("out_last", 64'(out_last), 64'(e_l[t]));
    check("input_YV", 64'(input_YV), 64'(last_yv));
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 48'h0, 48'h0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    frame_clr = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sel", 64'(sel_sum_cycle), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_yv", 64'(input_YV), 64'd0);
    pos = 0;
    last_yv = '0;
    for (int i = 0; i < 3; i++) begin
      e_v[t+i] = 1'b0;
      e_f[t+i] = 1'b0;
      e_l[t+i] = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    t++;
  endtask

  function automatic logic [47:0] rnd_word();
    logic [47:0] w;
    case ($urandom_range(0, 7))
      0: w = 48'h800000_800000;
      1: w = 48'h7FFFFF_800000;
      default: w = {$urandom(), $urandom()};
    endcase
    return w;
  endfunction

  initial begin
    repeat (2) @(negedge clock);
    check("init_out_valid", 64'(out_valid), 64'd0);
    check("init_yv", 64'(input_YV), 64'd0);
    reset = 1'b1;
    idle(2);

    // Unity times (0.5, 0.25)
    tick(1'b1, 48'h400000_000000, 48'h200000_100000, 1'b0);
    idle(3);
    check("unity_mul", 64'(input_YV), 64'h0000_200000_100000);

    // (-2)*(-2) saturates the real part
    tick(1'b1, 48'h800000_000000, 48'h800000_000000, 1'b0);
    idle(3);
    check("sat_mul", 64'(input_YV), 64'h0000_7FFFFF_000000);

    // Realign frame, then 8 back-to-back inputs
    pulse_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, rnd_word(), rnd_word(), 1'b0);
    idle(3);

    // Bubble pattern 1,0,1,1,0,0,1
    begin
      bit pat [7] = '{1, 0, 1, 1, 0, 0, 1};
      for (int i = 0; i < 7; i++) tick(pat[i], rnd_word(), rnd_word(), 1'b0);
    end
    idle(3);

    // Two inputs, then frame_clr with a valid input
    tick(1'b1, rnd_word(), rnd_word(), 1'b0);
    tick(1'b1, rnd_word(), rnd_word(), 1'b0);
    tick(1'b1, rnd_word(), rnd_word(), 1'b1);
    idle(4);

    // Reset with two products in flight
    tick(1'b1, rnd_word(), rnd_word(), 1'b0);
    tick(1'b1, rnd_word(), rnd_word(), 1'b0);
    pulse_reset();
    idle(3);
    tick(1'b1, rnd_word(), rnd_word(), 1'b0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else tick(($urandom_range(0, 3) != 0), rnd_word(), rnd_word(),
                ($urandom_range(0, 15) == 0));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yv_cmult_pipe.md
YV_CMULT_PIPE -- requirements
Module: yv_cmult_pipe

Interface
REQ-001 Parameter WIDTH, 48, packed complex word width: {real[47:24], imag[23:0]}, each half signed two's complement Q2.22.
REQ-002 Parameter FRAC, 22, fractional bits per component.
REQ-003 Parameter TERMS, 8, products per accumulation frame; legal range 2..64.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  y_in/v_in carry a product request this cycle.
REQ-007 y_in  input  WIDTH  complex Y operand.
REQ-008 v_in  input  WIDTH  complex V operand.
REQ-009 frame_clr  input  1  synchronous restart of the frame term counter.
REQ-010 input_YV  output  WIDTH  complex product Y*V, feeds the accumulator input of the same name.
REQ-011 out_valid  output  1  input_YV valid this cycle.
REQ-012 sel_sum_cycle  output  1  high with the first product of each frame; drives the accumulator restart select.
REQ-013 out_last  output  1  high with the last (TERMS-th) product of each frame.

Function
REQ-014 Products: re = yr*vr - yi*vi, im = yr*vi + yi*vr, with full-precision 48-bit partials and a 49-bit sum.
REQ-015 Scaling: arithmetic right shift by FRAC (truncation toward minus infinity), then saturation to 24-bit signed (0x7FFFFF / 0x800000), applied per component.
REQ-016 Fixed latency of 3 cycles: S1 registers the operands, S2 registers the four partial products, S3 registers the combined, scaled, saturated result.
REQ-017 out_valid is in_valid delayed by exactly 3 cycles; there is no backpressure and no stall.
REQ-018 While out_valid is low, input_YV holds its last value and sel_sum_cycle/out_last are 0.
REQ-019 The term counter (0..TERMS-1) advances only on cycles with in_valid=1 and wraps from TERMS-1 to 0.
REQ-020 A term is tagged first when the counter is 0 and last when the counter is TERMS-1; tags travel with the data through all 3 stages.
REQ-021 frame_clr=1 forces the counter to 0 for the current cycle's input. If in_valid is also 1, that input is tagged first and the counter becomes 1.
REQ-022 frame_clr does not disturb products already in flight.
REQ-023 Gaps in in_valid (bubbles) do not change frame position; a frame spans exactly TERMS valid inputs.

Reset
REQ-024 On reset low, immediately clear: all pipeline data and tag registers, the valid shift chain, and the term counter.
REQ-025 Outputs during and after reset: input_YV=0, out_valid=0, sel_sum_cycle=0, out_last=0.
REQ-026 Reset asserted mid-frame discards in-flight products; the first valid input after release is tagged first.

Structure
REQ-027 The shared package holds WIDTH, FRAC, the component width (WIDTH/2), the saturation limits, and the complex pack/unpack helpers; the accumulator uses the same package.
REQ-028 One sub-module, cmult_core, holds the four signed multipliers plus the S2/S3 combine, shift and saturate logic.
REQ-029 Frame counter and tag pipeline stay in the top level.

Verification
REQ-030 y=(1.0,0)=0x400000_000000, v=(0.5,0.25)=0x200000_100000, one valid pulse -> 3 cycles later out_valid=1, input_YV=0x200000_100000, sel_sum_cycle=1.
REQ-031 y=(-2.0,0)=0x800000_000000, v=(-2.0,0) -> input_YV real=0x7FFFFF (saturated), imag=0x000000.
REQ-032 TERMS=4, 8 back-to-back valid inputs -> sel_sum_cycle on output cycles 1 and 5, out_last on output cycles 4 and 8, out_valid high for 8 consecutive cycles.
REQ-033 TERMS=4, valid pattern 1,0,1,1,0,0,1 -> exactly 4 outputs; sel_sum_cycle on the 1st, out_last on the 4th, bubbles reproduced 3 cycles later.
REQ-034 TERMS=4, 2 valid inputs, then frame_clr=1 with in_valid=1 -> that third input emerges with sel_sum_cycle=1 and no out_last before it.
REQ-035 Reset pulsed low mid-frame with 2 products in flight -> outputs zero at once, no stale out_valid after release, and the next input is tagged first.
